// File: rtl/ahb_mtx_dec_param.sv
// ahb_mtx_dec_param: AHB bus-matrix input-port decoder. Routes one input stage to NUM_PORTS
// output stages via base/mask regions with a boot-remap alias. Unmapped accesses go to an
// integrated two-cycle ERROR default slave, and a sticky error log records them.
// Latency: sel_out/active_dec are combinational; the data-phase mux follows the selected port.
// The default slave ERROR response takes two cycles (wait, then ready).
// Backpressure: HREADYS qualifies the data-phase port register and the default-slave FSM.
// Ports: HCLK/HRESETn; address phase (HREADYS, sel_dec, decode_addr_dec, trans_dec, remap);
// output-stage returns (*_dec); sel_out/active_dec; HREADYOUTS/HRESPS/HRDATAS/HRUSERS;
// error log (err_clr in, err_valid/err_addr/err_count out).
module ahb_mtx_dec_param #(
    parameter int                      NUM_PORTS   = 4,
    parameter int                      RUSER_W     = 32,
    parameter logic [NUM_PORTS*22-1:0] REGION_BASE = {NUM_PORTS{22'h0}},
    parameter logic [NUM_PORTS*22-1:0] REGION_MASK = {NUM_PORTS{22'h0}},
    parameter int                      REMAP_PORT  = 1
) (
    input  logic                         HCLK,
    input  logic                         HRESETn,
    input  logic                         HREADYS,
    input  logic                         sel_dec,
    input  logic [21:0]                  decode_addr_dec,
    input  logic [1:0]                   trans_dec,
    input  logic                         remap,
    input  logic                         err_clr,
    input  logic [NUM_PORTS-1:0]         active_dec_in,
    input  logic [NUM_PORTS-1:0]         readyout_dec,
    input  logic [2*NUM_PORTS-1:0]       resp_dec,
    input  logic [32*NUM_PORTS-1:0]      rdata_dec,
    input  logic [RUSER_W*NUM_PORTS-1:0] ruser_dec,
    output logic [NUM_PORTS-1:0]         sel_out,
    output logic                         active_dec,
    output logic                         HREADYOUTS,
    output logic [1:0]                   HRESPS,
    output logic [31:0]                  HRDATAS,
    output logic [RUSER_W-1:0]           HRUSERS,
    output logic                         err_valid,
    output logic [21:0]                  err_addr,
    output logic [15:0]                  err_count
);

    // Port index space includes the default slave at index NUM_PORTS.
    localparam int            PW  = $clog2(NUM_PORTS + 1);
    localparam logic [PW-1:0] DFT = PW'(NUM_PORTS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ERR1 = 2'd1,
        ST_ERR2 = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] dec_port;
    logic [PW-1:0] addr_port;
    logic [PW-1:0] data_port;
    logic          found;
    logic          sel_dft;
    logic          err_start;
    logic          err_event;
    logic          dft_ready;
    logic [1:0]    dft_resp;

    // Region decode: first (lowest-index) enabled region that matches wins.
    always_comb begin
        dec_port = DFT;
        found    = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!found && (REGION_MASK[i*22 +: 22] != 22'h0) &&
                ((decode_addr_dec & REGION_MASK[i*22 +: 22]) ==
                 (REGION_BASE[i*22 +: 22] & REGION_MASK[i*22 +: 22]))) begin
                found    = 1'b1;
                dec_port = PW'(i);
            end
        end
        // Boot alias: region 0 is served by the remap port while remap is set.
        if (remap && found && (dec_port == '0)) begin
            dec_port = PW'(REMAP_PORT);
        end
    end

    // IDLE transfers keep the current data-phase port so selects stay steady.
    assign addr_port = (trans_dec == 2'b00) ? data_port : dec_port;
    assign sel_dft   = sel_dec && (addr_port == DFT);

    always_comb begin
        sel_out    = '0;
        active_dec = 1'b1;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (addr_port == PW'(i)) begin
                sel_out[i] = sel_dec;
                active_dec = active_dec_in[i];
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            data_port <= '0;
        end else if (HREADYS) begin
            data_port <= addr_port;
        end
    end

    // Data-phase return mux; the default slave drives zero data.
    always_comb begin
        HREADYOUTS = dft_ready;
        HRESPS     = dft_resp;
        HRDATAS    = 32'h0;
        HRUSERS    = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (data_port == PW'(i)) begin
                HREADYOUTS = readyout_dec[i];
                HRESPS     = resp_dec[i*2 +: 2];
                HRDATAS    = rdata_dec[i*32 +: 32];
                HRUSERS    = ruser_dec[i*RUSER_W +: RUSER_W];
            end
        end
    end

    // Default slave: NONSEQ/SEQ to an unmapped address gets a two-cycle ERROR.
    assign err_start = HREADYS && sel_dft && trans_dec[1];

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Ready/resp decode straight from the state register, so they are registered.
    always_comb begin
        state_nxt = ST_IDLE;
        dft_ready = 1'b1;
        dft_resp  = 2'b00;
        case (state)
            ST_IDLE: begin
                if (err_start) state_nxt = ST_ERR1;
            end
            ST_ERR1: begin
                dft_ready = 1'b0;
                dft_resp  = 2'b01;
                state_nxt = ST_ERR2;
            end
            ST_ERR2: begin
                dft_resp = 2'b01;
                if (err_start) state_nxt = ST_ERR1;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign err_event = (state_nxt == ST_ERR1) && (state != ST_ERR1);

    // Sticky log: first address kept, count saturates; clear beats a same-cycle event.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            err_valid <= 1'b0;
            err_addr  <= 22'h0;
            err_count <= 16'h0;
        end else if (err_clr) begin
            err_valid <= 1'b0;
            err_addr  <= 22'h0;
            err_count <= 16'h0;
        end else if (err_event) begin
            if (err_count != 16'hFFFF) begin
                err_count <= err_count + 16'h1;
            end
            if (!err_valid) begin
                err_valid <= 1'b1;
                err_addr  <= decode_addr_dec;
            end
        end
    end

endmodule
